// File: rtl/simd_nd_addr_walker.sv
// simd_nd_addr_walker: multi-group, N-dimensional strided address generator.
// Each group holds a trip count and a signed stride per loop level. A walk
// emits base + sum(idx[l] * stride[l]) once per ready/valid beat, with loop
// indices advancing like an odometer (loop 0 innermost).
// Optional build macro SIMD_WALKER_CTX_EN adds per-group pause/resume context.
module simd_nd_addr_walker #(
  parameter int ADDR_WIDTH = 48,
  parameter int STRIDE_W   = 16,
  parameter int COUNT_W    = 16,
  parameter int NUM_LOOPS  = 4,
  parameter int NUM_GROUPS = 4,
  parameter int LOOP_ID_W  = 2,
  parameter int GROUP_ID_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_v,
  input  logic [GROUP_ID_W-1:0] cfg_group,
  input  logic [LOOP_ID_W-1:0]  cfg_loop,
  input  logic [STRIDE_W-1:0]   cfg_stride,
  input  logic [COUNT_W-1:0]    cfg_count,
  output logic                  cfg_err,
  input  logic                  start,
  input  logic [GROUP_ID_W-1:0] start_group,
  input  logic                  start_resume,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef logic [NUM_LOOPS-1:0][COUNT_W-1:0]  cnt_vec_t;
  typedef logic [NUM_LOOPS-1:0][STRIDE_W-1:0] str_vec_t;

  str_vec_t stride_q [NUM_GROUPS];
  cnt_vec_t count_q  [NUM_GROUPS];

  state_t                state_q, state_d;
  logic [GROUP_ID_W-1:0] grp_q, grp_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  cnt_vec_t              idx_q, idx_d, idx_adv;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  cfg_we, beat, last;
  cnt_vec_t              cur_count;
  str_vec_t              cur_stride;

  // Address of an index vector: base plus sign-extended stride products, mod 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] walk_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input cnt_vec_t idx,
                                                      input str_vec_t stride);
    logic [ADDR_WIDTH-1:0] acc;
    logic [ADDR_WIDTH-1:0] ext;
    acc = base;
    for (int l = 0; l < NUM_LOOPS; l++) begin
      ext = {{(ADDR_WIDTH-STRIDE_W){stride[l][STRIDE_W-1]}}, stride[l]};
      acc = acc + ADDR_WIDTH'(idx[l]) * ext;
    end
    return acc;
  endfunction

  assign cur_count  = count_q[grp_q];
  assign cur_stride = stride_q[grp_q];
  assign beat       = valid_q & addr_ready;
  assign last       = (idx_q == cur_count);
  assign cfg_err_d  = cfg_v && (state_q == RUN) && (cfg_group == grp_q);
  assign cfg_we     = cfg_v && !cfg_err_d;

  // Configuration storage; a write to the group being walked is refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        stride_q[g] <= '0;
        count_q[g]  <= '0;
      end
    end else if (cfg_we) begin
      stride_q[cfg_group][cfg_loop] <= cfg_stride;
      count_q[cfg_group][cfg_loop]  <= cfg_count;
    end
  end

  // Odometer: loop 0 always steps; a loop at its count wraps and carries upward.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    idx_adv = idx_q;
    for (int l = 0; l < NUM_LOOPS; l++) begin
      if (carry) begin
        if (idx_q[l] == cur_count[l]) begin
          idx_adv[l] = '0;
        end else begin
          idx_adv[l] = idx_q[l] + COUNT_W'(1);
          carry      = 1'b0;
        end
      end
    end
  end

`ifdef SIMD_WALKER_CTX_EN
  logic [NUM_GROUPS-1:0] ctx_valid_q;
  logic [ADDR_WIDTH-1:0] ctx_base_q [NUM_GROUPS];
  cnt_vec_t              ctx_idx_q  [NUM_GROUPS];
  logic                  pause_take;

  // A pause that lands on the final beat is a normal completion instead.
  assign pause_take = (state_q == RUN) && pause && !(beat && last);

  // Saved walk context: written on pause, dropped on completion or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_valid_q <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        ctx_base_q[g] <= '0;
        ctx_idx_q[g]  <= '0;
      end
    end else if (pause_take) begin
      ctx_valid_q[grp_q] <= 1'b1;
      ctx_base_q[grp_q]  <= base_q;
      ctx_idx_q[grp_q]   <= idx_d;
    end else if ((state_q == RUN) && beat && last) begin
      ctx_valid_q[grp_q] <= 1'b0;
    end
  end
`else
  logic unused_ctx_inputs;
  assign unused_ctx_inputs = pause ^ start_resume;
`endif

  // Next-state: start capture, beat-driven index/address advance, completion.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    base_d  = base_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          grp_d   = start_group;
          valid_d = 1'b1;
          base_d  = base_addr;
          idx_d   = '0;
          addr_d  = base_addr;
`ifdef SIMD_WALKER_CTX_EN
          if (start_resume && ctx_valid_q[start_group]) begin
            base_d = ctx_base_q[start_group];
            idx_d  = ctx_idx_q[start_group];
            addr_d = walk_addr(ctx_base_q[start_group], ctx_idx_q[start_group],
                               stride_q[start_group]);
          end
`endif
        end
      end
      RUN: begin
        if (beat && last) begin
          state_d = IDLE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (beat) begin
            idx_d  = idx_adv;
            addr_d = walk_addr(base_q, idx_adv, cur_stride);
          end
`ifdef SIMD_WALKER_CTX_EN
          if (pause) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/simd_nd_addr_walker.md
Name: simd_nd_addr_walker

Overview:
- Multi-group, N-dimensional strided address generator for the SIMD datapath. It supersedes externally-sequenced walkers by owning its own loop counters.
- Per group, holds a trip count and signed stride for each loop. After start, emits one address per accepted ready/valid beat until every loop nest is exhausted.
- Sits between the SIMD instruction decoder (configuration) and the SIMD memory request port (address stream).

Parameters:
ADDR_WIDTH, 48, address width
STRIDE_W, 16, signed stride width (two's complement)
COUNT_W, 16, trip-count field width
NUM_LOOPS, 4, loop levels per group; loop 0 innermost
NUM_GROUPS, 4, independent configuration groups
LOOP_ID_W, 2, clog2(NUM_LOOPS)
GROUP_ID_W, 2, clog2(NUM_GROUPS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_v  in  1  configuration write strobe
cfg_group  in  GROUP_ID_W  group written
cfg_loop  in  LOOP_ID_W  loop level written
cfg_stride  in  STRIDE_W  signed stride for that loop
cfg_count  in  COUNT_W  trip count minus 1 (0 = one trip)
cfg_err  out  1  pulse: write dropped
start  in  1  start walk, sampled only in IDLE
start_group  in  GROUP_ID_W  group walked
start_resume  in  1  resume saved context (optional feature only)
base_addr  in  ADDR_WIDTH  walk base, captured on start
pause  in  1  suspend request (optional feature only)
addr_out  out  ADDR_WIDTH  generated address
addr_valid  out  1  addr_out valid
addr_ready  in  1  consumer accepts addr_out
busy  out  1  high in RUN
done  out  1  one-cycle pulse after last beat

Behaviour:

Reset:
- Forces IDLE. Clears all strides, counts, indices and addr_out to 0.
- addr_valid, busy, done and cfg_err are 0.
- A reset mid-walk abandons the walk. No done is produced.

Configuration:
- cfg_v writes stride[cfg_group][cfg_loop] and count[cfg_group][cfg_loop] in one cycle.
- Writes are legal in any state, except to the group being walked while busy. Such writes are dropped and cfg_err pulses in the following cycle.

States:
- IDLE → RUN on start. In the same edge: capture base_addr and start_group, zero all indices.
- RUN → IDLE on the beat (addr_valid & addr_ready) where every idx[l] == count[l]. done pulses in the cycle after that beat.
- start while busy is ignored.

Address and latency:
- addr_out = base + Σ idx[l] × sext(stride[l]), computed modulo 2^ADDR_WIDTH. Underflow and overflow wrap silently.
- First address equals base and appears with addr_valid high the cycle after start is accepted.

Handshake:
- Indices advance only on a beat. Throughput is one address per cycle while addr_ready stays high.
- While addr_valid is high and addr_ready is low, addr_out is held stable.
- addr_valid never drops without a beat (except on reset).

Index advance:
- On each beat, loop 0 increments.
- When idx[l] == count[l] and loop l advances, idx[l] resets to 0 and loop l+1 increments (odometer).
- Loops with count 0 contribute exactly one trip.

Timing:
- Stride/count reads use the group captured at start. Updates to other groups mid-walk have no effect on the active walk.
- addr_out is registered. No combinational path from addr_ready to addr_out.
- addr_ready → addr_valid is registered-next-state only.

Optional Feature:
SIMD_WALKER_CTX_EN
- Defined:
  - pause high in RUN takes effect on the next beat (or immediately if addr_valid is low or no beat is pending). It saves idx[*] and base into the per-group context, then returns to IDLE with no done pulse.
  - start with start_resume=1 restores that group's saved indices and base; base_addr is ignored. A group with no saved context resumes from index 0 with the current base_addr.
  - Completion or reset clears that group's saved context.
- Undefined: pause and start_resume are ignored and no context storage is built. Every start begins at index 0.

Test Plan:
1. Group1 config: L0 stride 4 count 2; L1 stride 100 count 1; L2/L3 count 0. base 0x1000, ready held high → 0x1000, 0x1004, 0x1008, 0x1064, 0x1068, 0x106C on consecutive cycles; done pulses one cycle after the 6th beat; busy falls with it.
2. Negative stride: L0 stride 0xFFF8 (−8) count 3, base 0x20 → 0x20, 0x18, 0x10, 0x08. Same stride, count 1, base 0x4 → 0x4, 0xFFFF_FFFF_FFFC.
3. Backpressure: during test 1, drop addr_ready for 3 cycles on the 0x1008 beat → addr_out stays 0x1008 and valid stays high for all 3 cycles; sequence resumes unchanged; total beats = 6.
4. Config hazard: during a group1 walk, write group1 L0 → cfg_err pulses once and the stream is unchanged. Write group2 L0 → no cfg_err, and a later group2 walk uses the new stride. start issued while busy is ignored.
5. Reset at the 3rd beat of test 1 → next cycle addr_valid=0, busy=0, no done. A new start on group1 emits only base, because counts are cleared.
6. (CTX_EN) In test 1, assert pause at the 0x1008 beat → IDLE, no done. Then start group1 with start_resume=1 → 0x1064, 0x1068, 0x106C, then done.
